// File: rtl/fifo_btn_ctrl_pkg.sv
// Shared types and default sizing for the button-driven FIFO controller.
package fifo_btn_ctrl_pkg;

   localparam int unsigned DEF_DATA_W          = 4;
   localparam int unsigned DEF_DEPTH           = 8;
   localparam int unsigned DEF_DEBOUNCE_CYCLES = 1000000;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WRITE   = 2'd1,
      READ    = 2'd2,
      CAPTURE = 2'd3
   } state_t;

endpackage

// File: rtl/fifo_btn_ctrl_btn_debounce.sv
// Active-low button: 2-flop synchronizer, stability counter and a one-cycle
// pulse on the debounced press (1->0) transition.
module btn_debounce
   import fifo_btn_ctrl_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
   input  logic clk,
   input  logic reset,
   input  logic btn,
   output logic press
);

   localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync_q0;
   logic             sync_q1;
   logic             level_q;
   logic [CNT_W-1:0] cnt_q;
   logic             settle_c;

   // Input has disagreed with the debounced level for the full window
   assign settle_c = (sync_q1 != level_q) && (cnt_q == CNT_MAX);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q0 <= 1'b1;
         sync_q1 <= 1'b1;
         level_q <= 1'b1;
         cnt_q   <= '0;
         press   <= 1'b0;
      end else begin
         sync_q0 <= btn;
         sync_q1 <= sync_q0;
         press   <= settle_c & ~sync_q1;
         if (sync_q1 == level_q) begin
            cnt_q <= '0;
         end else if (settle_c) begin
            level_q <= sync_q1;
            cnt_q   <= '0;
         end else begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/fifo_btn_ctrl.sv
// Push/pop button front end for an external FIFO: debounced press events drive
// single-cycle write/read strobes, track occupancy and flag misuse.
module fifo_btn_ctrl
   import fifo_btn_ctrl_pkg::*;
#(
   parameter int unsigned DATA_W          = DEF_DATA_W,
   parameter int unsigned DEPTH           = DEF_DEPTH,
   parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   localparam int unsigned LVL_W          = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push_btn,
   input  logic              pop_btn,
   input  logic [DATA_W-1:0] sw,
   input  logic              fifo_full,
   input  logic              fifo_empty,
   input  logic [DATA_W-1:0] fifo_rd_data,
   output logic              wr_en,
   output logic              rd_en,
   output logic [DATA_W-1:0] wr_data,
   output logic [DATA_W-1:0] disp_data,
   output logic [LVL_W-1:0]  level,
   output logic              ovf_err,
   output logic              udf_err,
   output logic              busy
);

   state_t            state_q;
   state_t            state_n;
   logic [DATA_W-1:0] sw_q0;
   logic [DATA_W-1:0] sw_q1;
   logic              push_press;
   logic              pop_press;
   logic              wr_en_n;
   logic              rd_en_n;
   logic [DATA_W-1:0] wr_data_n;
   logic [DATA_W-1:0] disp_data_n;
   logic [LVL_W-1:0]  level_n;
   logic              ovf_err_n;
   logic              udf_err_n;

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_push_db (
      .clk   (clk),
      .reset (reset),
      .btn   (push_btn),
      .press (push_press)
   );

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_pop_db (
      .clk   (clk),
      .reset (reset),
      .btn   (pop_btn),
      .press (pop_press)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sw_q0 <= '0;
         sw_q1 <= '0;
      end else begin
         sw_q0 <= sw;
         sw_q1 <= sw_q0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_n;
      end
   end

   // Pop has priority when both arrive; the loser is dropped silently
   always_comb begin
      state_n     = state_q;
      wr_en_n     = 1'b0;
      rd_en_n     = 1'b0;
      wr_data_n   = wr_data;
      disp_data_n = disp_data;
      level_n     = level;
      ovf_err_n   = ovf_err;
      udf_err_n   = udf_err;
      case (state_q)
         IDLE: begin
            if (pop_press && !fifo_empty) begin
               state_n = READ;
               rd_en_n = 1'b1;
            end else if (push_press) begin
               if (fifo_full) begin
                  ovf_err_n = 1'b1;
               end else begin
                  state_n   = WRITE;
                  wr_en_n   = 1'b1;
                  wr_data_n = sw_q1;
               end
            end else if (pop_press) begin
               udf_err_n = 1'b1;
            end
         end
         WRITE: begin
            state_n = IDLE;
            if (level < LVL_W'(DEPTH)) level_n = level + LVL_W'(1);
         end
         READ: begin
            state_n = CAPTURE;
            if (level != '0) level_n = level - LVL_W'(1);
         end
         CAPTURE: begin
            state_n     = IDLE;
            disp_data_n = fifo_rd_data;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_en     <= 1'b0;
         rd_en     <= 1'b0;
         wr_data   <= '0;
         disp_data <= '0;
         level     <= '0;
         ovf_err   <= 1'b0;
         udf_err   <= 1'b0;
         busy      <= 1'b0;
      end else begin
         wr_en     <= wr_en_n;
         rd_en     <= rd_en_n;
         wr_data   <= wr_data_n;
         disp_data <= disp_data_n;
         level     <= level_n;
         ovf_err   <= ovf_err_n;
         udf_err   <= udf_err_n;
         busy      <= (state_n != IDLE);
      end
   end

endmodule

// File: tb/tb_fifo_btn_ctrl.sv
// Directed table-driven bench for fifo_btn_ctrl with a short debounce window.
module tb_fifo_btn_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       push_btn;
   logic       pop_btn;
   logic [3:0] sw;
   logic       fifo_full;
   logic       fifo_empty;
   logic [3:0] fifo_rd_data;
   logic       wr_en;
   logic       rd_en;
   logic [3:0] wr_data;
   logic [3:0] disp_data;
   logic [3:0] level;
   logic       ovf_err;
   logic       udf_err;
   logic       busy;

   int checks = 0;
   int errors = 0;
   int wr_cnt;
   int rd_cnt;
   int both_cnt;
   logic [3:0] wr_seen;

   typedef struct {
      logic       push;
      logic       pop;
      logic [3:0] sw;
      logic       full;
      logic       empty;
      logic [3:0] rd_data;
      int         exp_wr;
      int         exp_rd;
      logic [3:0] exp_wr_data;
      logic [3:0] exp_disp;
      logic [3:0] exp_level;
      logic       exp_ovf;
      logic       exp_udf;
   } vec_t;

   vec_t vecs [15];

   fifo_btn_ctrl #(.DATA_W(4), .DEPTH(8), .DEBOUNCE_CYCLES(4)) dut (
      .clk          (clk),
      .reset        (reset),
      .push_btn     (push_btn),
      .pop_btn      (pop_btn),
      .sw           (sw),
      .fifo_full    (fifo_full),
      .fifo_empty   (fifo_empty),
      .fifo_rd_data (fifo_rd_data),
      .wr_en        (wr_en),
      .rd_en        (rd_en),
      .wr_data      (wr_data),
      .disp_data    (disp_data),
      .level        (level),
      .ovf_err      (ovf_err),
      .udf_err      (udf_err),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (wr_en) begin
         wr_cnt++;
         wr_seen = wr_data;
      end
      if (rd_en) rd_cnt++;
      if (wr_en && rd_en) both_cnt++;
   endtask

   task automatic clear_counts();
      wr_cnt   = 0;
      rd_cnt   = 0;
      both_cnt = 0;
      wr_seen  = 4'h0;
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_wr_en"},     int'(wr_en),     0);
      check({tag, "_rd_en"},     int'(rd_en),     0);
      check({tag, "_wr_data"},   int'(wr_data),   0);
      check({tag, "_disp_data"}, int'(disp_data), 0);
      check({tag, "_level"},     int'(level),     0);
      check({tag, "_ovf"},       int'(ovf_err),   0);
      check({tag, "_udf"},       int'(udf_err),   0);
      check({tag, "_busy"},      int'(busy),      0);
   endtask

   task automatic do_reset();
      reset    = 1'b1;
      push_btn = 1'b1;
      pop_btn  = 1'b1;
      repeat (3) tick();
      reset = 1'b0;
      repeat (2) tick();
   endtask

   initial begin
      reset        = 1'b1;
      push_btn     = 1'b1;
      pop_btn      = 1'b1;
      sw           = 4'h0;
      fifo_full    = 1'b0;
      fifo_empty   = 1'b0;
      fifo_rd_data = 4'h0;
      clear_counts();

      //        push  pop   sw    full  empty rd    wr rd wr_data disp  lvl  ovf   udf
      vecs[0]  = '{1'b1, 1'b0, 4'h1, 1'b0, 1'b0, 4'h0, 1, 0, 4'h1, 4'h0, 4'd1, 1'b0, 1'b0};
      vecs[1]  = '{1'b1, 1'b0, 4'h2, 1'b0, 1'b0, 4'h0, 1, 0, 4'h2, 4'h0, 4'd2, 1'b0, 1'b0};
      vecs[2]  = '{1'b1, 1'b0, 4'h3, 1'b0, 1'b0, 4'h0, 1, 0, 4'h3, 4'h0, 4'd3, 1'b0, 1'b0};
      vecs[3]  = '{1'b1, 1'b0, 4'h4, 1'b0, 1'b0, 4'h0, 1, 0, 4'h4, 4'h0, 4'd4, 1'b0, 1'b0};
      vecs[4]  = '{1'b1, 1'b0, 4'h5, 1'b0, 1'b0, 4'h0, 1, 0, 4'h5, 4'h0, 4'd5, 1'b0, 1'b0};
      vecs[5]  = '{1'b1, 1'b0, 4'h6, 1'b0, 1'b0, 4'h0, 1, 0, 4'h6, 4'h0, 4'd6, 1'b0, 1'b0};
      vecs[6]  = '{1'b1, 1'b0, 4'h7, 1'b0, 1'b0, 4'h0, 1, 0, 4'h7, 4'h0, 4'd7, 1'b0, 1'b0};
      vecs[7]  = '{1'b1, 1'b0, 4'h8, 1'b0, 1'b0, 4'h0, 1, 0, 4'h8, 4'h0, 4'd8, 1'b0, 1'b0};
      vecs[8]  = '{1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 4'h5, 0, 1, 4'h8, 4'h5, 4'd7, 1'b0, 1'b0};
      vecs[9]  = '{1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 4'hA, 0, 1, 4'h8, 4'hA, 4'd6, 1'b0, 1'b0};
      vecs[10] = '{1'b1, 1'b1, 4'hE, 1'b0, 1'b0, 4'h3, 0, 1, 4'h8, 4'h3, 4'd5, 1'b0, 1'b0};
      vecs[11] = '{1'b1, 1'b1, 4'h9, 1'b0, 1'b1, 4'h3, 1, 0, 4'h9, 4'h3, 4'd6, 1'b0, 1'b0};
      vecs[12] = '{1'b0, 1'b1, 4'h0, 1'b0, 1'b1, 4'h0, 0, 0, 4'h9, 4'h3, 4'd6, 1'b0, 1'b1};
      vecs[13] = '{1'b1, 1'b0, 4'hF, 1'b1, 1'b0, 4'h0, 0, 0, 4'h9, 4'h3, 4'd6, 1'b1, 1'b1};
      vecs[14] = '{1'b1, 1'b0, 4'h2, 1'b0, 1'b0, 4'h0, 1, 0, 4'h2, 4'h3, 4'd7, 1'b1, 1'b1};

      // Reset state while reset is held
      repeat (2) tick();
      check_reset_vals("rst");
      reset = 1'b0;
      repeat (2) tick();

      for (int i = 0; i < 15; i++) begin
         sw           = vecs[i].sw;
         fifo_full    = vecs[i].full;
         fifo_empty   = vecs[i].empty;
         fifo_rd_data = vecs[i].rd_data;
         clear_counts();
         push_btn = ~vecs[i].push;
         pop_btn  = ~vecs[i].pop;
         repeat (20) tick();
         push_btn = 1'b1;
         pop_btn  = 1'b1;
         repeat (12) tick();
         check($sformatf("v%0d_wr_cnt", i),  wr_cnt,           vecs[i].exp_wr);
         check($sformatf("v%0d_rd_cnt", i),  rd_cnt,           vecs[i].exp_rd);
         check($sformatf("v%0d_both", i),    both_cnt,         0);
         if (vecs[i].exp_wr != 0)
            check($sformatf("v%0d_wr_seen", i), int'(wr_seen), int'(vecs[i].exp_wr_data));
         check($sformatf("v%0d_wr_data", i), int'(wr_data),   int'(vecs[i].exp_wr_data));
         check($sformatf("v%0d_disp", i),    int'(disp_data), int'(vecs[i].exp_disp));
         check($sformatf("v%0d_level", i),   int'(level),     int'(vecs[i].exp_level));
         check($sformatf("v%0d_ovf", i),     int'(ovf_err),   int'(vecs[i].exp_ovf));
         check($sformatf("v%0d_udf", i),     int'(udf_err),   int'(vecs[i].exp_udf));
         check($sformatf("v%0d_busy", i),    int'(busy),      0);
      end

      // Bouncy press: short low pulses must not fire, the stable press fires once
      do_reset();
      sw           = 4'h7;
      fifo_full    = 1'b0;
      fifo_empty   = 1'b0;
      fifo_rd_data = 4'hC;
      clear_counts();
      for (int b = 0; b < 3; b++) begin
         push_btn = 1'b0;
         repeat (3) tick();
         push_btn = 1'b1;
         repeat (2) tick();
      end
      check("bounce_no_early_wr", wr_cnt, 0);
      push_btn = 1'b0;
      repeat (20) tick();
      push_btn = 1'b1;
      repeat (12) tick();
      check("bounce_wr_cnt",  wr_cnt,         1);
      check("bounce_wr_data", int'(wr_seen),  7);
      check("bounce_level",   int'(level),    1);

      // Reset landing during READ kills the strobe immediately
      clear_counts();
      pop_btn = 1'b0;
      for (int t = 0; t < 30 && !rd_en; t++) tick();
      check("rdrst_rd_seen", int'(rd_en), 1);
      reset = 1'b1;
      #1;
      check_reset_vals("rdrst");
      fifo_empty = 1'b1;
      repeat (2) tick();
      reset = 1'b0;

      // Button still held across reset release yields one pop event (FIFO empty)
      clear_counts();
      repeat (15) tick();
      check("held_udf",    int'(udf_err), 1);
      check("held_rd_cnt", rd_cnt,        0);
      check("held_level",  int'(level),   0);
      pop_btn = 1'b1;
      repeat (12) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fifo_btn_ctrl.md
FIFO_BTN_CTRL -- requirements
Module: fifo_btn_ctrl

Interface
REQ-001 Parameter DATA_W, default 4: switch and FIFO data width.
REQ-002 Parameter DEPTH, default 8: FIFO entry count; LVL_W = clog2(DEPTH)+1.
REQ-003 Parameter DEBOUNCE_CYCLES, default 1000000: stable-sample count (10 ms at 100 MHz).
REQ-004 clk  in  1  system clock; the single clock domain.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 push_btn / pop_btn  in  1 each  raw active-low buttons; 0 = pressed.
REQ-007 sw  in  DATA_W  raw switch value to be written.
REQ-008 fifo_full / fifo_empty  in  1 each  FIFO status flags, synchronous to clk.
REQ-009 fifo_rd_data  in  DATA_W  FIFO read data; valid the cycle after rd_en.
REQ-010 wr_en / rd_en  out  1 each  single-cycle FIFO write and read strobes.
REQ-011 wr_data  out  DATA_W  data presented with wr_en.
REQ-012 disp_data  out  DATA_W  last popped value.
REQ-013 level  out  LVL_W  controller occupancy count.
REQ-014 ovf_err / udf_err  out  1 each  sticky push-while-full and pop-while-empty flags.
REQ-015 busy  out  1  high in any state other than IDLE.

Function
REQ-016 Each button and sw pass through a 2-flop synchronizer; sync flops reset to 1 for buttons and 0 for sw.
REQ-017 Debounced button level updates only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts the count.
REQ-018 Press event = one-cycle pulse on a debounced 1->0 transition; release generates no event.
REQ-019 FSM states: IDLE, WRITE, READ, CAPTURE.
REQ-020 IDLE + push event + !fifo_full -> WRITE; sw (synchronized) captured into wr_data in the event cycle.
REQ-021 WRITE: wr_en=1 for exactly one cycle, level+1, -> IDLE.
REQ-022 IDLE + pop event + !fifo_empty -> READ; READ: rd_en=1 for exactly one cycle, level-1, -> CAPTURE.
REQ-023 CAPTURE: disp_data <= fifo_rd_data, -> IDLE.
REQ-024 Strobe latency: event in cycle E -> strobe high in cycle E+1; disp_data updated at the end of cycle E+2.
REQ-025 Push event while fifo_full: no wr_en, level unchanged, ovf_err set; FSM stays IDLE.
REQ-026 Pop event while fifo_empty: no rd_en, udf_err set; FSM stays IDLE.
REQ-027 Simultaneous push and pop events in IDLE: pop wins if !fifo_empty, otherwise push wins; the losing event is discarded and sets no error flag.
REQ-028 Events arriving while busy are discarded and set no error flag.
REQ-029 wr_en and rd_en are never high in the same cycle.
REQ-030 level saturates in 0..DEPTH and never wraps; wr_data holds its value outside WRITE.

Reset
REQ-031 Reset forces immediately: FSM=IDLE; wr_en=rd_en=0; wr_data=disp_data=0; level=0; ovf_err=udf_err=0; debounced levels=1 (released); debounce counters=0.
REQ-032 Reset asserted mid-WRITE or mid-READ aborts the strobe in the same cycle.
REQ-033 A button held low through reset deassertion yields one press event after sync plus DEBOUNCE_CYCLES cycles.

Structure
REQ-034 The shared package holds the FSM state enum (IDLE, WRITE, READ, CAPTURE) and the default DATA_W, DEPTH and DEBOUNCE_CYCLES constants.
REQ-035 One sub-module, btn_debounce (synchronizer + counter + fall-edge pulse), instantiated once per button.

Verification (benches set DEBOUNCE_CYCLES=4)
REQ-036 Reset, then push with sw=4'h1..4'h8 -> eight single-cycle wr_en strobes; wr_data sequence 1..8; level=8.
REQ-037 Press push with 3-cycle bounce pulses before a stable press -> exactly one wr_en.
REQ-038 Model fifo_full=1 and issue a push -> no wr_en; ovf_err=1 and stays 1 until reset.
REQ-039 FIFO preloaded with 5,A; pop twice -> rd_en strobes; disp_data=5 then A; level decrements by one per pop.
REQ-040 Push and pop pressed in the same cycle with the FIFO non-empty -> rd_en only; with the FIFO empty -> wr_en only; error flags stay 0.
REQ-041 Assert reset during READ -> rd_en=0 immediately; all outputs at their reset values.
